// File: rtl/msrv32_alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU; one operation in flight at a time.
// Optional build macro MSRV32_ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties instead of round-robin.
module msrv32_alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_n_in,

    input  logic             req0_valid_in,
    output logic             req0_ready_out,
    input  logic [3:0]       req0_opcode_in,
    input  logic [WIDTH-1:0] req0_op_1_in,
    input  logic [WIDTH-1:0] req0_op_2_in,

    input  logic             req1_valid_in,
    output logic             req1_ready_out,
    input  logic [3:0]       req1_opcode_in,
    input  logic [WIDTH-1:0] req1_op_1_in,
    input  logic [WIDTH-1:0] req1_op_2_in,

    output logic             rsp0_valid_out,
    input  logic             rsp0_ready_in,
    output logic [WIDTH-1:0] rsp0_result_out,

    output logic             rsp1_valid_out,
    input  logic             rsp1_ready_in,
    output logic [WIDTH-1:0] rsp1_result_out,

    output logic [WIDTH-1:0] alu_op_1_out,
    output logic [WIDTH-1:0] alu_op_2_out,
    output logic [3:0]       alu_opcode_out,
    input  logic [WIDTH-1:0] alu_result_in
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q;
    logic             last_grant_q;
    logic             grantee_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic [WIDTH-1:0] alu_op_1_q;
    logic [WIDTH-1:0] alu_op_2_q;
    logic [3:0]       alu_opcode_q;

    logic any_valid;
    logic grant;
    logic rsp_ready;

    always_comb begin
        any_valid = req0_valid_in | req1_valid_in;
        grant     = 1'b0;
        if (req0_valid_in && req1_valid_in) begin
`ifdef MSRV32_ALU_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_grant_q;
`endif
        end else begin
            grant = req1_valid_in;
        end
        rsp_ready = grantee_q ? rsp1_ready_in : rsp0_ready_in;
    end

    // Ready is gated by the reset pin so it drops the instant reset asserts.
    assign req0_ready_out  = rst_n_in && (state_q == StIdle) && any_valid && !grant;
    assign req1_ready_out  = rst_n_in && (state_q == StIdle) && any_valid && grant;
    assign rsp0_valid_out  = rsp_valid_q && !grantee_q;
    assign rsp1_valid_out  = rsp_valid_q && grantee_q;
    assign rsp0_result_out = rsp_result_q;
    assign rsp1_result_out = rsp_result_q;
    assign alu_op_1_out    = alu_op_1_q;
    assign alu_op_2_out    = alu_op_2_q;
    assign alu_opcode_out  = alu_opcode_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grantee_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            alu_op_1_q   <= '0;
            alu_op_2_q   <= '0;
            alu_opcode_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        alu_opcode_q <= grant ? req1_opcode_in : req0_opcode_in;
                        alu_op_1_q   <= grant ? req1_op_1_in : req0_op_1_in;
                        alu_op_2_q   <= grant ? req1_op_2_in : req0_op_2_in;
                        grantee_q    <= grant;
                        last_grant_q <= grant;
                        state_q      <= StExec;
                    end
                end
                StExec: begin
                    rsp_result_q <= alu_result_in;
                    state_q      <= StResp;
                end
                StResp: begin
                    // Valid is a register, so it rises one edge after the result is captured.
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_msrv32_alu_arbiter.sv
// Bench for msrv32_alu_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model. Honours MSRV32_ALU_ARB_FIXED_PRIO_EN when defined.
module tb_msrv32_alu_arbiter;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]       req0_opcode, req1_opcode;
    logic [WIDTH-1:0] req0_op_1, req0_op_2, req1_op_1, req1_op_2;
    logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [WIDTH-1:0] rsp0_result, rsp1_result;
    logic [WIDTH-1:0] alu_op_1, alu_op_2, alu_result;
    logic [3:0]       alu_opcode;

    int n_cmp = 0;
    int n_bad = 0;

    msrv32_alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .req0_valid_in   (req0_valid),
        .req0_ready_out  (req0_ready),
        .req0_opcode_in  (req0_opcode),
        .req0_op_1_in    (req0_op_1),
        .req0_op_2_in    (req0_op_2),
        .req1_valid_in   (req1_valid),
        .req1_ready_out  (req1_ready),
        .req1_opcode_in  (req1_opcode),
        .req1_op_1_in    (req1_op_1),
        .req1_op_2_in    (req1_op_2),
        .rsp0_valid_out  (rsp0_valid),
        .rsp0_ready_in   (rsp0_ready),
        .rsp0_result_out (rsp0_result),
        .rsp1_valid_out  (rsp1_valid),
        .rsp1_ready_in   (rsp1_ready),
        .rsp1_result_out (rsp1_result),
        .alu_op_1_out    (alu_op_1),
        .alu_op_2_out    (alu_op_2),
        .alu_opcode_out  (alu_opcode),
        .alu_result_in   (alu_result)
    );

    always #5 clk = ~clk;

    // Bench-side ALU: undefined codes return a recognisable pattern.
    function automatic logic [31:0] alu_ref(input logic [3:0] opc, input logic [31:0] a,
                                            input logic [31:0] b);
        case (opc)
            4'b0000: return a + b;
            4'b1000: return a - b;
            default: return a ^ b ^ 32'hA5A5_0000;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_opcode, alu_op_1, alu_op_2);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_opcode = 0; req0_op_1 = 0; req0_op_2 = 0;
        req1_valid = 0; req1_opcode = 0; req1_op_1 = 0; req1_op_2 = 0;
        rsp0_ready = 1; rsp1_ready = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic logic tie_winner(input logic last);
`ifdef MSRV32_ALU_ARB_FIXED_PRIO_EN
        return 1'b0;
`else
        return ~last;
`endif
    endfunction

    // Transaction-level model state
    logic        pend[2];
    logic [3:0]  p_opc[2];
    logic [31:0] p_a[2], p_b[2];
    logic        v[2], rr[2];
    logic        m_busy, m_g, m_last, g;
    int          m_age;
    logic [3:0]  m_opc;
    logic [31:0] m_a, m_b, m_res;
    int          n_gr, gr_who[8], gr_cyc[8];

    initial begin
        rst_n = 1;
        idle_inputs();

        // Single ADD from requester 0
        do_reset();
        req0_valid = 1; req0_opcode = 4'b0000; req0_op_1 = 5; req0_op_2 = 7;
        #1;
        check("add_rdy0", req0_ready, 1);
        check("add_rdy1", req1_ready, 0);
        @(negedge clk);
        req0_valid = 0;
        #1;
        check("add_alu_opc", alu_opcode, 4'b0000);
        check("add_alu_op1", alu_op_1, 5);
        check("add_alu_op2", alu_op_2, 7);
        check("add_v_n0", rsp0_valid, 0);
        @(negedge clk);
        check("add_v_n1", rsp0_valid, 0);
        @(negedge clk);
        check("add_v_n2", rsp0_valid, 1);
        check("add_res", rsp0_result, 32'h0000_000C);
        check("add_v1", rsp1_valid, 0);
        @(negedge clk);
        check("add_done_v0", rsp0_valid, 0);
        check("add_done_v1", rsp1_valid, 0);

        // Both requesters always valid: grant order and spacing
        do_reset();
        req0_valid = 1; req1_valid = 1;
        n_gr = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            check("tie_not_both", req0_ready & req1_ready, 0);
            if ((req0_ready || req1_ready) && n_gr < 8) begin
                gr_who[n_gr] = req1_ready;
                gr_cyc[n_gr] = c;
                n_gr++;
            end
            @(negedge clk);
        end
        check("tie_n_grants", n_gr, 5);
        for (int i = 0; i < 4; i++) begin
            if (i < n_gr) begin
`ifdef MSRV32_ALU_ARB_FIXED_PRIO_EN
                check("tie_who", gr_who[i], 0);
`else
                check("tie_who", gr_who[i], i % 2);
`endif
                check("tie_cyc", gr_cyc[i], 4 * i);
            end
        end

        // SUB from requester 1 with back-pressure on the response
        do_reset();
        req1_valid = 1; req1_opcode = 4'b1000; req1_op_1 = 0; req1_op_2 = 1;
        rsp1_ready = 0;
        #1;
        check("sub_rdy1", req1_ready, 1);
        @(negedge clk);
        req1_valid = 0;
        req0_valid = 1; req0_opcode = 4'b0000; req0_op_1 = 1; req0_op_2 = 1;
        #1;
        check("sub_rdy0_exec", req0_ready, 0);
        @(negedge clk);
        check("sub_v_early", rsp1_valid, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("sub_hold_v", rsp1_valid, 1);
            check("sub_hold_res", rsp1_result, 32'hFFFF_FFFF);
            check("sub_hold_rdy0", req0_ready, 0);
            check("sub_hold_v0", rsp0_valid, 0);
            @(negedge clk);
        end
        rsp1_ready = 1;
        @(negedge clk);
        #1;
        check("sub_after_v1", rsp1_valid, 0);
        check("sub_after_rdy0", req0_ready, 1);

        // Undefined opcode passes straight through
        do_reset();
        req0_valid = 1; req0_opcode = 4'b1111; req0_op_1 = 3; req0_op_2 = 4;
        #1;
        check("undef_rdy0", req0_ready, 1);
        @(negedge clk);
        req0_valid = 0;
        #1;
        check("undef_opc", alu_opcode, 4'b1111);
        @(negedge clk);
        @(negedge clk);
        check("undef_v", rsp0_valid, 1);
        check("undef_res", rsp0_result, 32'hA5A5_0007);

        // Reset asserted during EXEC
        do_reset();
        req0_valid = 1; req0_opcode = 4'b0000; req0_op_1 = 1; req0_op_2 = 2;
        @(negedge clk);
        req0_valid = 0;
        #1;
        check("rst_pre_op1", alu_op_1, 1);
        rst_n = 0;
        req0_valid = 1; req1_valid = 1;
        #1;
        check("rst_rdy0", req0_ready, 0);
        check("rst_rdy1", req1_ready, 0);
        check("rst_v0", rsp0_valid, 0);
        check("rst_v1", rsp1_valid, 0);
        check("rst_op1", alu_op_1, 0);
        check("rst_op2", alu_op_2, 0);
        check("rst_opc", alu_opcode, 0);
        check("rst_res0", rsp0_result, 0);
        check("rst_res1", rsp1_result, 0);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_rsp0", rsp0_valid, 0);
            check("rst_no_rsp1", rsp1_valid, 0);
        end
        req0_valid = 1; req1_valid = 1;
        #1;
        check("rst_tie_rdy0", req0_ready, 1);
        check("rst_tie_rdy1", req1_ready, 0);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 2; k++) pend[k] = 0;
        m_busy = 0; m_age = 0; m_g = 0; m_last = 1;
        m_opc = 0; m_a = 0; m_b = 0; m_res = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(2) == 0) begin
                    pend[k]  = 1;
                    p_opc[k] = 4'($urandom_range(15));
                    p_a[k]   = $urandom;
                    p_b[k]   = $urandom;
                end
                // Dropping valid while busy must be harmless
                v[k]  = pend[k] && !(m_busy && $urandom_range(3) == 0);
                rr[k] = 1'($urandom_range(1));
            end
            req0_valid = v[0]; req0_opcode = p_opc[0]; req0_op_1 = p_a[0]; req0_op_2 = p_b[0];
            req1_valid = v[1]; req1_opcode = p_opc[1]; req1_op_1 = p_a[1]; req1_op_2 = p_b[1];
            rsp0_ready = rr[0]; rsp1_ready = rr[1];
            #1;
            g = (v[0] && v[1]) ? tie_winner(m_last) : v[1];
            check("rnd_rdy0", req0_ready, !m_busy && (v[0] || v[1]) && !g);
            check("rnd_rdy1", req1_ready, !m_busy && (v[0] || v[1]) && g);
            check("rnd_v0", rsp0_valid, m_busy && m_age >= 2 && !m_g);
            check("rnd_v1", rsp1_valid, m_busy && m_age >= 2 && m_g);
            if (m_busy) begin
                check("rnd_alu_opc", alu_opcode, m_opc);
                check("rnd_alu_op1", alu_op_1, m_a);
                check("rnd_alu_op2", alu_op_2, m_b);
                if (m_age >= 2) begin
                    check("rnd_res0", rsp0_result, m_res);
                    check("rnd_res1", rsp1_result, m_res);
                end
            end
            @(posedge clk);
            if (!m_busy) begin
                if (v[0] || v[1]) begin
                    m_busy = 1; m_age = 0; m_g = g; m_last = g;
                    m_opc = p_opc[g]; m_a = p_a[g]; m_b = p_b[g];
                    m_res = alu_ref(m_opc, m_a, m_b);
                    pend[g] = 0;
                end
            end else if (m_age >= 2 && rr[m_g]) begin
                m_busy = 0;
            end else begin
                m_age++;
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
